avalon_pkt_gen: RTL and testbench

AVALON_PKT_GEN -- requirements
Module: avalon_pkt_gen

---
 rtl/avalon_pkt_gen.sv | 176 +++++++++++++++++
 tb/tb_avalon_pkt_gen.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pkt_gen.sv
// Avalon-ST test pattern generator: bursts of counter, LFSR or fixed words
// with programmable burst length, burst count and inter-burst gap.
//
// state | meaning
// IDLE  | waiting for cfg_start, outputs quiet
// RUN   | presenting words, out_valid=1
// GAP   | idle cycles between bursts, out_valid=0
// DRAIN | stop requested while stalled, hold word until accepted
module avalon_pkt_gen #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [LEN_W-1:0]  cfg_count,
  input  logic [7:0]        cfg_gap,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       words_sent
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] pattern_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic [7:0]        gap_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  word_cnt_q;
  logic [LEN_W-1:0]  burst_cnt_q;
  logic [7:0]        gap_cnt_q;
  logic [31:0]       words_sent_q;
  logic              done_q;

  logic              accept;
  logic              start_ok;
  logic              last_word;
  logic              last_burst;
  logic [DATA_W-1:0] lfsr_next;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-1:0] first_word;
  logic [31:0]       words_sent_inc;

  assign out_valid  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign out_data   = data_q;
  assign words_sent = words_sent_q;

  assign accept     = out_valid & out_ready;
  assign start_ok   = cfg_start && !cfg_stop && (cfg_len != '0);
  assign last_word  = (word_cnt_q == len_q - LEN_W'(1));
  assign last_burst = (count_q != '0) && (burst_cnt_q == count_q - LEN_W'(1));
  assign words_sent_inc = (words_sent_q == '1) ? words_sent_q : words_sent_q + 32'd1;

  assign lfsr_next = {data_q[DATA_W-2:0],
                      data_q[DATA_W-1] ^ data_q[DATA_W-2] ^ data_q[DATA_W-4] ^ data_q[DATA_W-5]};

  always_comb begin
    word_next = pattern_q;
    case (mode_q)
      2'd0:    word_next = data_q + DATA_W'(1);
      2'd1:    word_next = lfsr_next;
      default: word_next = pattern_q;
    endcase
  end

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  always_comb begin
    first_word = cfg_pattern;
    case (cfg_mode)
      2'd0:    first_word = '0;
      2'd1:    first_word = (cfg_pattern == '0) ? DATA_W'(1) : cfg_pattern;
      default: first_word = cfg_pattern;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      pattern_q    <= '0;
      len_q        <= '0;
      count_q      <= '0;
      gap_q        <= '0;
      data_q       <= '0;
      word_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      words_sent_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            mode_q       <= cfg_mode;
            pattern_q    <= cfg_pattern;
            len_q        <= cfg_len;
            count_q      <= cfg_count;
            gap_q        <= cfg_gap;
            data_q       <= first_word;
            word_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            words_sent_q <= '0;
            state_q      <= S_RUN;
          end
        end

        S_RUN: begin
          if (accept) begin
            words_sent_q <= words_sent_inc;
            data_q       <= word_next;
            if (cfg_stop) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else if (last_word) begin
              word_cnt_q <= '0;
              if (last_burst) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end else begin
                // Continuous runs let the burst index wrap; it is never compared.
                burst_cnt_q <= burst_cnt_q + LEN_W'(1);
                if (gap_q != 8'd0) begin
                  state_q   <= S_GAP;
                  gap_cnt_q <= gap_q;
                end
              end
            end else begin
              word_cnt_q <= word_cnt_q + LEN_W'(1);
            end
          end else if (cfg_stop) begin
            state_q <= S_DRAIN;
          end
        end

        S_GAP: begin
          if (cfg_stop) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else if (gap_cnt_q == 8'd1) begin
            state_q <= S_RUN;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end

        S_DRAIN: begin
          if (accept) begin
            words_sent_q <= words_sent_inc;
            state_q      <= S_IDLE;
            done_q       <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_pkt_gen.sv
// Self-checking bench for avalon_pkt_gen: directed scenarios plus randomized
// runs compared cycle by cycle against a word-sequence reference model.
module tb_avalon_pkt_gen;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        cfg_start;
  logic        cfg_stop;
  logic [1:0]  cfg_mode;
  logic [63:0] cfg_pattern;
  logic [15:0] cfg_len;
  logic [15:0] cfg_count;
  logic [7:0]  cfg_gap;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [31:0] words_sent;

  avalon_pkt_gen #(.DATA_W(64), .LEN_W(16)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .cfg_start   (cfg_start),
    .cfg_stop    (cfg_stop),
    .cfg_mode    (cfg_mode),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_count   (cfg_count),
    .cfg_gap     (cfg_gap),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .words_sent  (words_sent)
  );

  always #5 clk_clk = ~clk_clk;

  int passes = 0;
  int total  = 0;

  // Reference model: expected word stream and run bookkeeping.
  logic        m_active = 1'b0;
  logic        m_drain = 1'b0;
  logic        m_done_pend = 1'b0;
  int          m_gap_left = 0;
  int          m_in_burst = 0;
  int          m_bursts = 0;
  logic [31:0] m_n = '0;
  logic [63:0] m_word = '0;
  logic [1:0]  m_mode = '0;
  logic [63:0] m_pat = '0;
  int          m_len = 0;
  int          m_count = 0;
  int          m_gap = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bound_fail(input string tag);
    total = total + 1;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  function automatic logic [63:0] lfsr_adv(input logic [63:0] d);
    return {d[62:0], d[63] ^ d[62] ^ d[60] ^ d[59]};
  endfunction

  function automatic logic [63:0] succ(input logic [63:0] d);
    case (m_mode)
      2'd0:    return d + 64'd1;
      2'd1:    return lfsr_adv(d);
      default: return m_pat;
    endcase
  endfunction

  task automatic finish_run();
    m_active    = 1'b0;
    m_drain     = 1'b0;
    m_done_pend = 1'b1;
  endtask

  // Observe outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic step(input logic rdy, input logic stp, input logic strt);
    logic ev;
    @(negedge clk_clk);
    ev = m_active && (m_gap_left == 0);
    chk("valid", {63'd0, out_valid}, {63'd0, ev});
    chk("busy", {63'd0, busy}, {63'd0, m_active});
    chk("done", {63'd0, done}, {63'd0, m_done_pend});
    chk("words_sent", {32'd0, words_sent}, {32'd0, m_n});
    if (ev) chk("data", out_data, m_word);
    if (prev_stall) chk("stall_hold", out_data, prev_data);
    prev_stall = ev && !rdy;
    prev_data  = out_data;
    out_ready  = rdy;
    cfg_stop   = stp;
    cfg_start  = strt;
    m_done_pend = 1'b0;

    if (!m_active) begin
      if (strt && !stp && cfg_len != 16'd0) begin
        m_active   = 1'b1;
        m_drain    = 1'b0;
        m_mode     = cfg_mode;
        m_pat      = cfg_pattern;
        m_len      = int'(cfg_len);
        m_count    = int'(cfg_count);
        m_gap      = int'(cfg_gap);
        m_n        = '0;
        m_in_burst = 0;
        m_bursts   = 0;
        m_gap_left = 0;
        if (cfg_mode == 2'd0) m_word = '0;
        else if (cfg_mode == 2'd1) m_word = (cfg_pattern == 64'd0) ? 64'd1 : cfg_pattern;
        else m_word = cfg_pattern;
      end
    end else if (ev) begin
      if (rdy) begin
        m_n        = m_n + 32'd1;
        m_in_burst = m_in_burst + 1;
        m_word     = succ(m_word);
        if (stp || m_drain) begin
          finish_run();
        end else if (m_in_burst == m_len) begin
          m_in_burst = 0;
          m_bursts   = m_bursts + 1;
          if (m_count != 0 && m_bursts == m_count) finish_run();
          else m_gap_left = m_gap;
        end
      end else if (stp) begin
        m_drain = 1'b1;
      end
    end else begin
      if (stp) finish_run();
      else m_gap_left = m_gap_left - 1;
    end
  endtask

  task automatic scramble_cfg();
    cfg_mode    = 2'($urandom_range(3));
    cfg_pattern = {$urandom, $urandom};
    cfg_len     = 16'($urandom);
    cfg_count   = 16'($urandom);
    cfg_gap     = 8'($urandom);
  endtask

  // Start a run, then change every config input to prove they were latched.
  task automatic start_only(input logic [1:0] mode, input logic [63:0] pat,
                            input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap);
    cfg_mode    = mode;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_count   = cnt;
    cfg_gap     = gap;
    step(1'b1, 1'b0, 1'b1);
    @(posedge clk_clk);
    #1;
    scramble_cfg();
  endtask

  task automatic run_cfg(input logic [1:0] mode, input logic [63:0] pat,
                         input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap,
                         input int rdy_pct, input int max_cyc);
    start_only(mode, pat, len, cnt, gap);
    for (int i = 0; i < max_cyc && m_active; i++)
      step(($urandom_range(99) < rdy_pct), 1'b0, m_active && ($urandom_range(7) == 0));
    if (m_active) bound_fail("run_timeout");
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic hit;
    reset_reset = 1'b1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    out_ready = 1'b0;
    cfg_mode = '0; cfg_pattern = '0; cfg_len = '0; cfg_count = '0; cfg_gap = '0;
    repeat (3) @(negedge clk_clk);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_words", {32'd0, words_sent}, 64'd0);
    reset_reset = 1'b0;

    run_cfg(2'd0, 64'd0, 16'd4, 16'd2, 8'd0, 100, 100);
    chk("b2b_words_sent", {32'd0, words_sent}, 64'd8);
    run_cfg(2'd2, 64'hDEADBEEF_CAFEF00D, 16'd3, 16'd2, 8'd5, 100, 100);
    run_cfg(2'd1, 64'd0, 16'd3, 16'd1, 8'd0, 100, 50);
    run_cfg(2'd1, 64'h8000_0000_0000_0000, 16'd3, 16'd1, 8'd0, 100, 50);
    run_cfg(2'd0, 64'd0, 16'd7, 16'd5, 8'd3, 50, 1000);
    run_cfg(2'd3, {$urandom, $urandom}, 16'd2, 16'd3, 8'd1, 70, 500);

    for (int r = 0; r < 8; r++)
      run_cfg(2'($urandom_range(3)), ($urandom_range(3) == 0) ? 64'd0 : {$urandom, $urandom},
              16'($urandom_range(6, 1)), 16'($urandom_range(4, 1)), 8'($urandom_range(3)),
              $urandom_range(100, 30), 2000);

    // Zero-length start and stop+start in IDLE are both ignored.
    cfg_len = 16'd0;
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    cfg_len = 16'd4;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Continuous run, stop while stalled: drain then done.
    start_only(2'd0, 64'd0, 16'd5, 16'd0, 8'd2);
    for (int i = 0; i < 40; i++) step(($urandom_range(99) < 60), 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_active && m_gap_left == 0) begin
        step(1'b0, 1'b1, 1'b0);
        hit = 1'b1;
      end else begin
        step(1'b1, 1'b0, 1'b0);
      end
    end
    if (!hit) bound_fail("drain_wait");
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Stop during a gap.
    start_only(2'd0, 64'd0, 16'd2, 16'd0, 8'd6);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (m_active && m_gap_left > 0) begin
        step(1'b1, 1'b1, 1'b0);
        hit = 1'b1;
      end else begin
        step(1'b1, 1'b0, 1'b0);
      end
    end
    if (!hit) bound_fail("gap_wait");
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Stop coincident with acceptance.
    start_only(2'd1, {$urandom, $urandom}, 16'd4, 16'd0, 8'd1);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_active && m_gap_left == 0) begin
        step(1'b1, 1'b1, 1'b0);
        hit = 1'b1;
      end else begin
        step(1'b1, 1'b0, 1'b0);
      end
    end
    if (!hit) bound_fail("accept_stop_wait");
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-burst, then a clean restart.
    start_only(2'd0, 64'd0, 16'd8, 16'd0, 8'd0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    @(posedge clk_clk);
    #2;
    reset_reset = 1'b1;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_words", {32'd0, words_sent}, 64'd0);
    chk("arst_data", out_data, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    m_active = 1'b0; m_drain = 1'b0; m_done_pend = 1'b0;
    m_gap_left = 0; m_n = '0; prev_stall = 1'b0;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    run_cfg(2'd0, 64'd0, 16'd4, 16'd1, 8'd0, 100, 50);
    chk("restart_words_sent", {32'd0, words_sent}, 64'd4);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
